// File: rtl/fir_pkg.sv
// Shared types and default sizing for the time-multiplexed FIR MAC sequencer.
package fir_pkg;

  localparam int N_DEF      = 16;
  localparam int N_TAPS_DEF = 4;
  localparam int N_MULT_DEF = 12;

  localparam int TAP_W  = $clog2(N_TAPS_DEF);
  localparam int PROD_W = N_DEF + N_MULT_DEF;
  localparam int ACC_W  = PROD_W + TAP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Bus bundle for the FIR MAC sequencer: sample input, result output,
// coefficient config port, flush, status and a debug view of the FSM state.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Once valid is raised it stays high, with its data stable, until
// that transfer edge. The producer keeps this for in_valid/sample; the block
// keeps it for out_valid/out.
interface fir_mac_sequencer_if #(
  parameter int N      = 16,
  parameter int N_TAPS = 4,
  parameter int N_MULT = 12
);
  localparam int TAP_W = $clog2(N_TAPS);
  localparam int ACC_W = N + N_MULT + TAP_W;

  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        sample;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out;
  logic                coef_we;
  logic [TAP_W-1:0]    coef_addr;
  logic [N_MULT-1:0]   coef_data;
  logic                flush;
  logic                busy;
  fir_pkg::state_t     dbg_state;

  modport master (
    output in_valid, sample, out_ready, coef_we, coef_addr, coef_data, flush,
    input  in_ready, out_valid, out, busy, dbg_state
  );

  modport slave (
    input  in_valid, sample, out_ready, coef_we, coef_addr, coef_data, flush,
    output in_ready, out_valid, out, busy, dbg_state
  );
endinterface

// File: rtl/fir_delay_line.sv
// N_TAPS x N sample shift register: entry 0 is the newest sample.
// Clear has priority over shift so a flush always discards the history.
module fir_delay_line #(
  parameter int N      = 16,
  parameter int N_TAPS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_shift,
  input  logic                      i_clear,
  input  logic [N-1:0]              i_din,
  input  logic [$clog2(N_TAPS)-1:0] i_rd_idx,
  output logic [N-1:0]              o_rd_data
);

  logic [N-1:0] r_dl [N_TAPS];

  // Shift in a new sample or clear the whole history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) r_dl[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < N_TAPS; i++) r_dl[i] <= '0;
    end else if (i_shift) begin
      r_dl[0] <= i_din;
      for (int i = 1; i < N_TAPS; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  assign o_rd_data = r_dl[i_rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiplier walks the taps, one per cycle.
// The product is registered before accumulation, so the last accumulate
// lands one edge after the last multiply; out_valid therefore rises
// N_TAPS+1 edges after the sample is accepted.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int N_MULT = N_MULT_DEF
) (
  input  logic clk,
  input  logic rst,
  fir_mac_sequencer_if.slave bus
);

  localparam int TW = $clog2(N_TAPS);
  localparam int PW = N + N_MULT;
  localparam int AW = PW + TW;

  state_t            r_state;
  logic [TW:0]       r_tap;
  logic [PW-1:0]     r_prod;
  logic [AW-1:0]     r_acc;
  logic [AW-1:0]     r_out;
  logic              r_out_valid;
  logic [N_MULT-1:0] r_coef [N_TAPS];

  logic              w_idle;
  logic              w_accept;
  logic              w_clear;
  logic [TW-1:0]     w_tap_idx;
  logic [N-1:0]      w_dl_rd;
  logic [PW-1:0]     w_prod;

  assign w_idle    = (r_state == IDLE);
  // Flush beats a sample in the same cycle; the producer keeps valid held.
  assign w_accept  = w_idle && bus.in_valid && !bus.flush;
  assign w_clear   = w_idle && bus.flush;
  // The counter runs one past the last tap to drain the product register;
  // the wrapped index on that cycle reads a product nobody uses.
  assign w_tap_idx = r_tap[TW-1:0];
  assign w_prod    = PW'(w_dl_rd) * PW'(r_coef[w_tap_idx]);

  fir_delay_line #(.N(N), .N_TAPS(N_TAPS)) u_delay_line (
    .clk       (clk),
    .rst_n     (rst),
    .i_shift   (w_accept),
    .i_clear   (w_clear),
    .i_din     (bus.sample),
    .i_rd_idx  (w_tap_idx),
    .o_rd_data (w_dl_rd)
  );

  // Coefficient bank: writable only while idle so a running sum never sees a change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) r_coef[i] <= '0;
    end else if (w_idle && bus.coef_we) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Control FSM with the tap counter, product pipeline, accumulator and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_tap       <= '0;
      r_prod      <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tap   <= '0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_prod <= w_prod;
          r_acc  <= r_acc + AW'(r_prod);
          r_tap  <= r_tap + 1'b1;
          if (r_tap[TW]) begin
            r_out       <= r_acc + AW'(r_prod);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_idle;
  assign bus.busy      = !w_idle;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.dbg_state = r_state;

endmodule
